// File: rtl/sync_sched_pkg.sv
// Shared constants and the timer-slot record for the pulse delay scheduler.
package sync_sched_pkg;
  localparam int N_REQ_DEF  = 4;
  localparam int DLY_W_DEF  = 8;
  localparam int DEPTH_DEF  = 4;

  // Slot record fields are sized for the largest supported configuration.
  localparam int SLOT_ID_W  = 8;
  localparam int SLOT_CNT_W = 32;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                  busy;
    logic [SLOT_ID_W-1:0]  id;
    logic [SLOT_CNT_W-1:0] count;
  } slot_t;
endpackage

// File: rtl/sched_slot.sv
// One countdown timer slot: load, decrement to zero, expire and free.
module sched_slot
  import sync_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [SLOT_ID_W-1:0]  load_id,
  input  logic [SLOT_CNT_W-1:0] load_cnt,
  output logic                  busy,
  output logic [SLOT_ID_W-1:0]  id,
  output logic                  expire,
  output logic                  expire_next
);
  slot_t slot_q, slot_d;

  assign busy        = slot_q.busy;
  assign id          = slot_q.id;
  assign expire      = slot_q.busy && (slot_q.count == '0);
  assign expire_next = slot_q.busy && (slot_q.count == SLOT_CNT_W'(1));

  always_comb begin
    slot_d = slot_q;
    if (expire)
      slot_d.busy = 1'b0;
    else if (slot_q.busy)
      slot_d.count = slot_q.count - SLOT_CNT_W'(1);
    // A grant may reuse the slot at the same edge it expires.
    if (load) begin
      slot_d.busy  = 1'b1;
      slot_d.id    = load_id;
      slot_d.count = load_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) slot_q <= '0;
    else        slot_q <= slot_d;
  end
endmodule

// File: rtl/pulse_delay_sched.sv
// Round-robin request scheduler feeding a pool of countdown slots that emit delayed strobes.
module pulse_delay_sched
  import sync_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DLY_W = DLY_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int SEL_W = sel_w(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [DLY_W-1:0] cfg_dly,
  input  logic [N_REQ-1:0] req,
  input  logic             ovf_clr,
  output logic [N_REQ-1:0] out,
  output logic [N_REQ-1:0] pend,
  output logic [N_REQ-1:0] ovf,
  output logic             full
);
  localparam int IDX_W = sel_w(DEPTH);

  logic [N_REQ-1:0][DLY_W-1:0] dly_q, dly_d;
  logic [N_REQ-1:0]            pend_q, pend_d, ovf_q, ovf_d, out_q, out_d;
  logic [SEL_W-1:0]            last_q, last_d;

  logic [DEPTH-1:0]                s_busy, s_exp, s_expn, load;
  logic [DEPTH-1:0][SLOT_ID_W-1:0] s_id;
  logic                            free_found, gnt_found, gnt;
  logic [IDX_W-1:0]                free_idx;
  logic [SEL_W-1:0]                gnt_id;
  logic [N_REQ-1:0]                gnt_vec, dup;
  logic [SLOT_ID_W-1:0]            load_id;
  logic [SLOT_CNT_W-1:0]           load_cnt;

  assign out  = out_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;
  assign full = &s_busy;

  assign load_id  = SLOT_ID_W'(gnt_id);
  assign load_cnt = SLOT_CNT_W'(dly_q[gnt_id]);

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    sched_slot u_slot (
      .clk         (clk),
      .reset       (reset),
      .load        (load[s]),
      .load_id     (load_id),
      .load_cnt    (load_cnt),
      .busy        (s_busy[s]),
      .id          (s_id[s]),
      .expire      (s_exp[s]),
      .expire_next (s_expn[s])
    );
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int s = DEPTH-1; s >= 0; s--)
      if (!s_busy[s] || s_exp[s]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(s);
      end

    // Walk the search order backwards so the first pending requester after last_q wins.
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (pend_q[(int'(last_q) + k) % N_REQ]) begin
        gnt_found = 1'b1;
        gnt_id    = SEL_W'((int'(last_q) + k) % N_REQ);
      end

    gnt     = gnt_found && free_found;
    gnt_vec = '0;
    if (gnt) gnt_vec[gnt_id] = 1'b1;
    for (int s = 0; s < DEPTH; s++)
      load[s] = gnt && (free_idx == IDX_W'(s));

    // Strobes are registered one cycle ahead of expiry; a zero delay fires straight off the grant.
    out_d = '0;
    dup   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int s = 0; s < DEPTH; s++)
        if (s_expn[s] && (s_id[s] == SLOT_ID_W'(i))) begin
          dup[i]   = dup[i] | out_d[i];
          out_d[i] = 1'b1;
        end
      if (gnt_vec[i] && (dly_q[i] == '0)) begin
        dup[i]   = dup[i] | out_d[i];
        out_d[i] = 1'b1;
      end
    end

    pend_d = (pend_q & ~gnt_vec) | req;
    ovf_d  = (ovf_clr ? '0 : ovf_q) | (req & pend_q & ~gnt_vec) | dup;
    last_d = gnt ? gnt_id : last_q;

    dly_d = dly_q;
    if (cfg_we && (int'(cfg_sel) < N_REQ)) dly_d[cfg_sel] = cfg_dly;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dly_q  <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      out_q  <= '0;
      last_q <= SEL_W'(N_REQ-1);
    end else begin
      dly_q  <= dly_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      out_q  <= out_d;
      last_q <= last_d;
    end
  end
endmodule
